tiny_rv_wb_arbiter: RTL and testbench
=====================================

# tiny_rv_wb_arbiter

Two-master, one-slave pipelined Wishbone arbiter that shares the core's single memory bus between instruction fetch (master 0) and the load/store unit (master 1). It grants whole bus cycles (CYC-locked), routes ACK/ERR/STALL back to the owner only, and runs a watchdog that aborts a granted cycle the slave never answers. It sits between the core's two bus masters and the system interconnect.

## Interface
- DATA_PRIORITY, 1: 1 = master 1 always wins simultaneous requests; 0 = round-robin on last owner.
- TIMEOUT_CYCLES, 255: cycles a granted cycle may wait for ACK/ERR before abort; 0 disables the watchdog.
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_mN_cyc, i_mN_stb, i_mN_we  in  1 each  master N (N=0,1) bus request.
- i_mN_addr  in  30  master N word address.
- i_mN_data  in  32  master N write data.
- i_mN_sel  in  4  master N byte select.
- o_mN_ack, o_mN_err, o_mN_stall  out  1 each  responses to master N.
- o_mN_data  out  32  read data to master N (both driven from i_wb_data).
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave-side request.
- o_wb_addr  out  30, o_wb_data  out  32, o_wb_sel  out  4  slave-side address/data/select.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each; i_wb_data  in  32  slave responses.

## Operation
- States: IDLE, GNT0, GNT1, ABORT0, ABORT1. Reset -> IDLE, last_owner = 0, watchdog = 0.
- IDLE: only i_mN_cyc requests; i_mN_stb is ignored. Only m0 cyc -> GNT0; only m1 cyc -> GNT1; both -> GNT1 if DATA_PRIORITY, else the master that is not last_owner.
- GNTn: o_wb_cyc/stb/we/addr/data/sel = master n inputs; o_mn_stall = i_wb_stall; o_mn_ack = i_wb_ack; o_mn_err = i_wb_err. last_owner <= n on entry.
- GNTn release: i_mn_cyc low -> GNT(other) if other cyc high, else IDLE. No idle cycle is inserted.
- Non-owner (and both masters in IDLE/ABORT): stall = 1, ack = 0, err = 0.
- Watchdog counts cycles in GNTn with o_wb_cyc high and no i_wb_ack/i_wb_err; cleared on ack, err or state change. When it reaches TIMEOUT_CYCLES: o_mn_err = 1 for that one cycle, next state ABORTn.
- ABORTn: o_wb_cyc = o_wb_stb = 0; wait for i_mn_cyc low, then IDLE (or GNT(other) if it requests). Slave ack/err in ABORT is dropped.
- i_reset mid-cycle: next cycle IDLE, o_wb_cyc low, no ack/err to any master.
- Counter width $clog2(TIMEOUT_CYCLES+1); never wraps. It saturates only via abort.

## Timing
- Reset values: o_wb_cyc = o_wb_stb = o_wb_we = 0, o_mN_ack = o_mN_err = 0, o_mN_stall = 1; address/data/sel outputs = 0 in IDLE.
- Grant latency: cyc+stb at cycle k in IDLE -> o_wb_stb visible at k+1; master sees stall = 1 at k.
- Slave-side request and response paths are combinational muxes selected by the registered state. No extra latency after grant.
- Master handover: owner drops cyc at cycle k -> other master's stb on bus at k+1.
- Timeout error is asserted exactly TIMEOUT_CYCLES cycles after the first unanswered granted cycle, for one cycle.

## Structure
- Package tiny_rv_wb_pkg: arb_state_t enum (IDLE, GNT0, GNT1, ABORT0, ABORT1) and master index constants M_FETCH = 0, M_DATA = 1.
- Sub-module tiny_rv_wb_watchdog: parameterized counter with clear/enable inputs and a one-cycle expire output.

## Test plan
- Single m1 load: cyc+stb at cycle 1, slave ack at cycle 3 with data 0xDEADBEEF -> o_m1_ack at 3, o_m1_data = 0xDEADBEEF, o_m0_ack stays 0.
- Simultaneous m0/m1 cyc with DATA_PRIORITY = 1 -> GNT1. Repeat with DATA_PRIORITY = 0 after an m1 cycle -> GNT0.
- Back-to-back handover: m1 owns and m0 is waiting; m1 drops cyc at cycle k -> o_wb_addr = m0 addr and stb high at k+1, no idle cycle.
- Slave stall: i_wb_stall held 4 cycles -> only the owner sees stall and bus outputs stay stable; the non-owner's stall stays 1.
- Timeout with TIMEOUT_CYCLES = 8 and no slave ack -> o_m0_err pulses once, o_wb_cyc drops the same cycle, a late ack is dropped, and the arbiter is IDLE after m0 releases.
- i_reset asserted while in GNT1 waiting for ack -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/tiny_rv_wb_pkg.sv
// Shared types and constants for the tiny_rv Wishbone arbiter slice.
package tiny_rv_wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GNT0,
        GNT1,
        ABORT0,
        ABORT1
    } arb_state_t;

    localparam logic M_FETCH = 1'b0;
    localparam logic M_DATA  = 1'b1;

    // A disabled watchdog (limit 0) still needs a legal one-bit counter.
    function automatic int wdWidth(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/tiny_rv_wb_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and
// flags expiry while the count sits at the limit.
module tiny_rv_wb_watchdog
    import tiny_rv_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = wdWidth(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    // Holds at the limit instead of wrapping; the arbiter aborts from there.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = (TIMEOUT_CYCLES > 0) && i_enable && (r_count == LIMIT);

endmodule

// File: rtl/tiny_rv_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: fetch (m0) and load/store (m1)
// share one slave port with whole-cycle grants and a no-answer watchdog.
module tiny_rv_wb_arbiter
    import tiny_rv_wb_pkg::*;
#(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [3:0]  i_m0_sel,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [3:0]  i_m1_sel,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic [31:0] o_m1_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_lastOwner;
    logic       w_expire;
    logic       w_wdEnable;
    logic       w_wdClear;

    assign w_wdEnable = ((r_state == GNT0) && i_m0_cyc) || ((r_state == GNT1) && i_m1_cyc);
    assign w_wdClear  = (w_next != r_state) || i_wb_ack || i_wb_err;

    tiny_rv_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_wdClear),
        .i_enable(w_wdEnable),
        .o_expire(w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_lastOwner <= M_FETCH;
        end else begin
            r_state <= w_next;
            if ((w_next == GNT0) && (r_state != GNT0)) begin
                r_lastOwner <= M_FETCH;
            end else if ((w_next == GNT1) && (r_state != GNT1)) begin
                r_lastOwner <= M_DATA;
            end
        end
    end

    // Releases hand straight over to a waiting master so no idle cycle appears.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_next = ((DATA_PRIORITY != 0) || (r_lastOwner == M_FETCH)) ? GNT1 : GNT0;
                end else if (i_m0_cyc) begin
                    w_next = GNT0;
                end else if (i_m1_cyc) begin
                    w_next = GNT1;
                end
            end
            GNT0: begin
                if (w_expire)       w_next = ABORT0;
                else if (!i_m0_cyc) w_next = i_m1_cyc ? GNT1 : IDLE;
            end
            GNT1: begin
                if (w_expire)       w_next = ABORT1;
                else if (!i_m1_cyc) w_next = i_m0_cyc ? GNT0 : IDLE;
            end
            ABORT0: if (!i_m0_cyc) w_next = i_m1_cyc ? GNT1 : IDLE;
            ABORT1: if (!i_m1_cyc) w_next = i_m0_cyc ? GNT0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // An expiring cycle is dropped from the bus in the same cycle its error is reported.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = '0;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        o_m1_stall = 1'b1;
        case (r_state)
            GNT0: begin
                o_wb_cyc   = i_m0_cyc & ~w_expire;
                o_wb_stb   = i_m0_stb & ~w_expire;
                o_wb_we    = i_m0_we;
                o_wb_addr  = i_m0_addr;
                o_wb_data  = i_m0_data;
                o_wb_sel   = i_m0_sel;
                o_m0_stall = i_wb_stall;
                o_m0_ack   = i_wb_ack & ~w_expire;
                o_m0_err   = i_wb_err | w_expire;
            end
            GNT1: begin
                o_wb_cyc   = i_m1_cyc & ~w_expire;
                o_wb_stb   = i_m1_stb & ~w_expire;
                o_wb_we    = i_m1_we;
                o_wb_addr  = i_m1_addr;
                o_wb_data  = i_m1_data;
                o_wb_sel   = i_m1_sel;
                o_m1_stall = i_wb_stall;
                o_m1_ack   = i_wb_ack & ~w_expire;
                o_m1_err   = i_wb_err | w_expire;
            end
            default: ;
        endcase
    end

    assign o_m0_data = i_wb_data;
    assign o_m1_data = i_wb_data;

endmodule

// File: tb/tb_tiny_rv_wb_arbiter.sv
// Bench for tiny_rv_wb_arbiter: two instances (fixed data priority and
// round-robin) share stimulus and are compared against a bus-level model.
module tb_tiny_rv_wb_arbiter;

    localparam int TIMEOUT = 8;
    localparam logic [74:0] RESET_VEC = {69'd0, 6'b001001};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mCyc [2] = '{1'b0, 1'b0};
    logic        mStb [2] = '{1'b0, 1'b0};
    logic        mWe  [2] = '{1'b0, 1'b0};
    logic [29:0] mAddr[2] = '{30'd0, 30'd0};
    logic [31:0] mData[2] = '{32'd0, 32'd0};
    logic [3:0]  mSel [2] = '{4'd0, 4'd0};
    logic        wbAckIn = 1'b0, wbErrIn = 1'b0, wbStallIn = 1'b0;
    logic [31:0] wbDataIn = 32'd0;

    logic        wbCyc[2], wbStb[2], wbWe[2];
    logic [29:0] wbAddr[2];
    logic [31:0] wbDataOut[2];
    logic [3:0]  wbSel[2];
    logic        mAck[2][2], mErr[2][2], mStall[2][2];
    logic [31:0] mRdata[2][2];

    int nChecks = 0;
    int nErrors = 0;

    // Model: who owns the bus (-1 none), who is being aborted, last owner, unanswered cycles.
    int mOwner[2] = '{-1, -1};
    int mAbort[2] = '{-1, -1};
    int mLast [2] = '{0, 0};
    int mWait [2] = '{0, 0};

    always #5 clk = ~clk;

    tiny_rv_wb_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(TIMEOUT)) dutP (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(mCyc[0]), .i_m0_stb(mStb[0]), .i_m0_we(mWe[0]),
        .i_m0_addr(mAddr[0]), .i_m0_data(mData[0]), .i_m0_sel(mSel[0]),
        .o_m0_ack(mAck[0][0]), .o_m0_err(mErr[0][0]), .o_m0_stall(mStall[0][0]), .o_m0_data(mRdata[0][0]),
        .i_m1_cyc(mCyc[1]), .i_m1_stb(mStb[1]), .i_m1_we(mWe[1]),
        .i_m1_addr(mAddr[1]), .i_m1_data(mData[1]), .i_m1_sel(mSel[1]),
        .o_m1_ack(mAck[0][1]), .o_m1_err(mErr[0][1]), .o_m1_stall(mStall[0][1]), .o_m1_data(mRdata[0][1]),
        .o_wb_cyc(wbCyc[0]), .o_wb_stb(wbStb[0]), .o_wb_we(wbWe[0]),
        .o_wb_addr(wbAddr[0]), .o_wb_data(wbDataOut[0]), .o_wb_sel(wbSel[0]),
        .i_wb_ack(wbAckIn), .i_wb_stall(wbStallIn), .i_wb_err(wbErrIn), .i_wb_data(wbDataIn)
    );

    tiny_rv_wb_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(TIMEOUT)) dutR (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(mCyc[0]), .i_m0_stb(mStb[0]), .i_m0_we(mWe[0]),
        .i_m0_addr(mAddr[0]), .i_m0_data(mData[0]), .i_m0_sel(mSel[0]),
        .o_m0_ack(mAck[1][0]), .o_m0_err(mErr[1][0]), .o_m0_stall(mStall[1][0]), .o_m0_data(mRdata[1][0]),
        .i_m1_cyc(mCyc[1]), .i_m1_stb(mStb[1]), .i_m1_we(mWe[1]),
        .i_m1_addr(mAddr[1]), .i_m1_data(mData[1]), .i_m1_sel(mSel[1]),
        .o_m1_ack(mAck[1][1]), .o_m1_err(mErr[1][1]), .o_m1_stall(mStall[1][1]), .o_m1_data(mRdata[1][1]),
        .o_wb_cyc(wbCyc[1]), .o_wb_stb(wbStb[1]), .o_wb_we(wbWe[1]),
        .o_wb_addr(wbAddr[1]), .o_wb_data(wbDataOut[1]), .o_wb_sel(wbSel[1]),
        .i_wb_ack(wbAckIn), .i_wb_stall(wbStallIn), .i_wb_err(wbErrIn), .i_wb_data(wbDataIn)
    );

    function automatic logic [74:0] actualOut(input int inst);
        return {wbCyc[inst], wbStb[inst], wbWe[inst], wbAddr[inst], wbDataOut[inst], wbSel[inst],
                mAck[inst][0], mErr[inst][0], mStall[inst][0],
                mAck[inst][1], mErr[inst][1], mStall[inst][1]};
    endfunction

    function automatic logic [74:0] expectedOut(input int inst);
        logic        cyc, stb, we, timedOut;
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        ack[2], err[2], stall[2];
        int          n;
        cyc = 0; stb = 0; we = 0; a = '0; d = '0; s = '0;
        ack = '{1'b0, 1'b0}; err = '{1'b0, 1'b0}; stall = '{1'b1, 1'b1};
        n = mOwner[inst];
        if (n >= 0) begin
            timedOut = (mWait[inst] == TIMEOUT) && mCyc[n];
            cyc = mCyc[n] && !timedOut;
            stb = mStb[n] && !timedOut;
            we = mWe[n]; a = mAddr[n]; d = mData[n]; s = mSel[n];
            stall[n] = wbStallIn;
            ack[n] = wbAckIn && !timedOut;
            err[n] = wbErrIn || timedOut;
        end
        return {cyc, stb, we, a, d, s, ack[0], err[0], stall[0], ack[1], err[1], stall[1]};
    endfunction

    task automatic modelAdvance(input int inst);
        int n, o, pick;
        if (rst) begin
            mOwner[inst] = -1; mAbort[inst] = -1; mLast[inst] = 0; mWait[inst] = 0;
        end else if (mOwner[inst] < 0 && mAbort[inst] < 0) begin
            if (mCyc[0] && mCyc[1]) pick = (inst == 0) ? 1 : 1 - mLast[inst];
            else if (mCyc[0])       pick = 0;
            else if (mCyc[1])       pick = 1;
            else                    pick = -1;
            if (pick >= 0) begin
                mOwner[inst] = pick; mLast[inst] = pick; mWait[inst] = 0;
            end
        end else if (mOwner[inst] >= 0) begin
            n = mOwner[inst]; o = 1 - n;
            if (mWait[inst] == TIMEOUT && mCyc[n]) begin
                mAbort[inst] = n; mOwner[inst] = -1; mWait[inst] = 0;
            end else if (!mCyc[n]) begin
                mWait[inst] = 0;
                if (mCyc[o]) begin mOwner[inst] = o; mLast[inst] = o; end
                else mOwner[inst] = -1;
            end else if (wbAckIn || wbErrIn) begin
                mWait[inst] = 0;
            end else if (mWait[inst] < TIMEOUT) begin
                mWait[inst] = mWait[inst] + 1;
            end
        end else begin
            n = mAbort[inst]; o = 1 - n;
            if (!mCyc[n]) begin
                mAbort[inst] = -1;
                if (mCyc[o]) begin mOwner[inst] = o; mLast[inst] = o; mWait[inst] = 0; end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) modelAdvance(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
        mCyc[m] = cyc; mStb[m] = stb; mWe[m] = we; mAddr[m] = a; mData[m] = d; mSel[m] = s;
    endtask

    task automatic idleInputs();
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        wbAckIn = 0; wbErrIn = 0; wbStallIn = 0; wbDataIn = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        idleInputs();
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (actualOut(i) !== RESET_VEC) begin
                nErrors++;
                $display("[TB] FAIL reset_state inst%0d: got %h want %h", i, actualOut(i), RESET_VEC);
            end
        end
        tick();
        rst = 0;
    endtask

    task automatic test_single_load();
        applyStimulus(1, 1, 1, 0, 30'h0ABC, '0, 4'hF);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (mStall[i][1] !== 1'b1 || wbStb[i] !== 1'b0) begin
                nErrors++;
                $display("[TB] FAIL load_request inst%0d: stall=%b stb=%b want 1 0", i, mStall[i][1], wbStb[i]);
            end
        end
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (wbStb[i] !== 1'b1 || wbAddr[i] !== 30'h0ABC || mStall[i][1] !== 1'b0) begin
                nErrors++;
                $display("[TB] FAIL load_grant inst%0d: stb=%b addr=%h stall=%b want 1 0abc 0",
                         i, wbStb[i], wbAddr[i], mStall[i][1]);
            end
        end
        tick();
        wbAckIn = 1;
        wbDataIn = 32'hDEADBEEF;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (mAck[i][1] !== 1'b1 || mRdata[i][1] !== 32'hDEADBEEF || mAck[i][0] !== 1'b0) begin
                nErrors++;
                $display("[TB] FAIL load_ack inst%0d: m1ack=%b data=%h m0ack=%b want 1 deadbeef 0",
                         i, mAck[i][1], mRdata[i][1], mAck[i][0]);
            end
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_priority();
        applyStimulus(0, 1, 1, 0, 30'h111, '0, 4'hF);
        applyStimulus(1, 1, 1, 0, 30'h222, '0, 4'hF);
        tick();
        @(negedge clk);
        nChecks++;
        if (wbAddr[0] !== 30'h222 || mStall[0][0] !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL priority_fixed: addr=%h m0stall=%b want 222 1", wbAddr[0], mStall[0][0]);
        end
        nChecks++;
        if (wbAddr[1] !== 30'h111 || mStall[1][1] !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL priority_rr: addr=%h m1stall=%b want 111 1", wbAddr[1], mStall[1][1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        applyStimulus(1, 0, 0, 0, '0, '0, '0);
        tick();
        @(negedge clk);
        nChecks++;
        if (wbCyc[0] !== 1'b1 || wbStb[0] !== 1'b1 || wbAddr[0] !== 30'h111 || mStall[0][0] !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL handover: cyc=%b stb=%b addr=%h m0stall=%b want 1 1 111 0",
                     wbCyc[0], wbStb[0], wbAddr[0], mStall[0][0]);
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_stall();
        applyStimulus(1, 1, 1, 1, 30'h3_0F0F, 32'hCAFE_0123, 4'h5);
        wbStallIn = 1;
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nChecks++;
            if (mStall[0][1] !== 1'b1 || mStall[0][0] !== 1'b1 || wbStb[0] !== 1'b1 || wbWe[0] !== 1'b1 ||
                wbAddr[0] !== 30'h3_0F0F || wbDataOut[0] !== 32'hCAFE_0123 || wbSel[0] !== 4'h5) begin
                nErrors++;
                $display("[TB] FAIL stall_hold c%0d: got %h", c, actualOut(0));
            end
            tick();
        end
        wbStallIn = 0;
        wbAckIn = 1;
        @(negedge clk);
        nChecks++;
        if (mStall[0][1] !== 1'b0 || mStall[0][0] !== 1'b1 || mAck[0][1] !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL stall_release: m1stall=%b m0stall=%b m1ack=%b want 0 1 1",
                     mStall[0][1], mStall[0][0], mAck[0][1]);
        end
        tick();
        idleInputs();
        tick();
    endtask

    task automatic test_timeout();
        int errCount[2];
        int errAt[2];
        logic cycAtErr[2];
        errCount = '{0, 0}; errAt = '{-1, -1}; cycAtErr = '{1'b1, 1'b1};
        applyStimulus(0, 1, 1, 0, 30'h777, '0, 4'hF);
        tick();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (mErr[i][0] === 1'b1) begin
                    errCount[i]++; errAt[i] = c; cycAtErr[i] = wbCyc[i];
                end
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (errCount[i] != 1 || errAt[i] != TIMEOUT || cycAtErr[i] !== 1'b0) begin
                nErrors++;
                $display("[TB] FAIL timeout inst%0d: pulses=%0d at=%0d cyc=%b want 1 %0d 0",
                         i, errCount[i], errAt[i], cycAtErr[i], TIMEOUT);
            end
        end
        wbAckIn = 1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (mAck[i][0] !== 1'b0 || mErr[i][0] !== 1'b0 || wbCyc[i] !== 1'b0) begin
                nErrors++;
                $display("[TB] FAIL late_ack inst%0d: ack=%b err=%b cyc=%b want 0 0 0",
                         i, mAck[i][0], mErr[i][0], wbCyc[i]);
            end
        end
        tick();
        wbAckIn = 0;
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (actualOut(i) !== RESET_VEC) begin
                nErrors++;
                $display("[TB] FAIL after_abort inst%0d: got %h want %h", i, actualOut(i), RESET_VEC);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        applyStimulus(1, 1, 1, 0, 30'h555, '0, 4'h3);
        tick();
        tick();
        rst = 1;
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (actualOut(i) !== RESET_VEC) begin
                nErrors++;
                $display("[TB] FAIL reset_mid inst%0d: got %h want %h", i, actualOut(i), RESET_VEC);
            end
        end
        tick();
        rst = 0;
        idleInputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(99) < 12) mCyc[m] = ~mCyc[m];
                mStb[m]  = 1'($urandom_range(1));
                mWe[m]   = 1'($urandom_range(1));
                mAddr[m] = 30'($urandom);
                mData[m] = $urandom;
                mSel[m]  = 4'($urandom_range(15));
            end
            wbAckIn   = ($urandom_range(99) < 15);
            wbErrIn   = ($urandom_range(99) < 4);
            wbStallIn = ($urandom_range(99) < 30);
            wbDataIn  = $urandom;
            rst       = ($urandom_range(199) == 0);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                nChecks++;
                if (actualOut(i) !== expectedOut(i)) begin
                    nErrors++;
                    $display("[TB] FAIL random c%0d inst%0d: got %h want %h", c, i, actualOut(i), expectedOut(i));
                end
                nChecks++;
                if (mRdata[i][0] !== wbDataIn || mRdata[i][1] !== wbDataIn) begin
                    nErrors++;
                    $display("[TB] FAIL read_data c%0d inst%0d: got %h %h want %h",
                             c, i, mRdata[i][0], mRdata[i][1], wbDataIn);
                end
            end
            tick();
        end
        rst = 0;
        idleInputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_priority();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
